cpu_datapath: RTL and testbench

Multi-cycle datapath for the 16-bit, 4-register CPU. It sits directly downstream of the control FSM and executes that FSM's per-state control outputs. It holds the register file, the add/sub ALU, and the inter-state holding registers: ALU result, store data, memory data, destination and flags. It also drives the single shared memory port for both instruction fetch and load/store data.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/cpu_regfile.sv | 34 +++
 rtl/cpu_datapath.sv | 115 +++++++++++
 tb/tb_cpu_datapath.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit, 4-register multi-cycle CPU.
// Widths, ALU op encodings and opcode constants used by both control and datapath.
package cpu_pkg;

    localparam int DATA_W   = 16;
    localparam int REG_AW   = 2;
    localparam int NUM_REGS = 1 << REG_AW;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_LOAD  = 3'b100,
        OP_STORE = 3'b101
    } opcode_e;

endpackage

// File: rtl/cpu_regfile.sv
// Register file: two combinational read ports and one synchronous write port.
// All entries are ordinary writable registers, cleared by the asynchronous reset.
module cpu_regfile
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] raddr_a_i,
    input  logic [REG_AW-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // NOTE: the array is reset entry by entry, so it maps onto flops rather than a RAM;
    // that is what lets reset clear every register and abort any pending write-back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/cpu_datapath.sv
// Multi-cycle datapath: register file, add/sub ALU, inter-state holding registers
// and the shared instruction/data memory port, driven by the control FSM's strobes.
module cpu_datapath
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic              alu_op,
    input  logic              immediate,
    input  logic [DATA_W-1:0] imm_in,
    input  logic              exec_strobe,
    input  logic              reg_we,
    input  logic              addr_sel,
    input  logic              mem_we,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wen,
    output logic [DATA_W-1:0] alu_q,
    output logic              zero,
    output logic              carry,
    output logic              ovf,
    output logic              store_err
);

    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] wb_data;

    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] mdr_q;
    logic [REG_AW-1:0] dst_q;
    logic              mem_q;
    logic              carry_q;
    logic              ovf_q;
    logic              store_err_q;

    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] alu_d;
    logic              carry_d;
    logic              ovf_d;

    // Write-back reads only the latched dst_q/mem_q, so a new instruction can
    // be executing on the same edge without disturbing the previous result.
    assign wb_data = mem_q ? mdr_q : alu_q;

    cpu_regfile u_regfile (
        .clk       (clk),
        .reset     (reset),
        .raddr_a_i (rs1),
        .raddr_b_i (rs2),
        .rdata_a_o (rf_a),
        .rdata_b_o (rf_b),
        .we_i      (reg_we),
        .waddr_i   (dst_q),
        .wdata_i   (wb_data)
    );

    // Subtraction is A + ~B + 1, so carry-out means "no borrow" and the overflow
    // test uses the inverted operand as the effective B.
    // NOTE: every output of this block is assigned on every path, so no latch can form.
    always_comb begin
        op_b    = immediate ? imm_in : rf_b;
        b_eff   = (alu_op == ALU_SUB) ? ~op_b : op_b;
        sum     = {1'b0, rf_a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, alu_op};
        alu_d   = sum[DATA_W-1:0];
        carry_d = sum[DATA_W];
        ovf_d   = (rf_a[DATA_W-1] == b_eff[DATA_W-1]) && (alu_d[DATA_W-1] != rf_a[DATA_W-1]);
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values,
    // which the same-edge exec/write-back overlap depends on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_q       <= '0;
            b_q         <= '0;
            mdr_q       <= '0;
            dst_q       <= '0;
            mem_q       <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            store_err_q <= 1'b0;
        end else begin
            if (exec_strobe) begin
                alu_q   <= alu_d;
                b_q     <= rf_b;
                dst_q   <= immediate ? rs2 : rd;
                mem_q   <= immediate;
                carry_q <= carry_d;
                ovf_q   <= ovf_d;
            end
            if (addr_sel && !mem_we) begin
                mdr_q <= mem_rdata;
            end
            if (mem_we && !addr_sel) begin
                store_err_q <= 1'b1;
            end
        end
    end

    assign mem_addr  = addr_sel ? alu_q : pc_in;
    assign mem_wdata = b_q;
    assign mem_wen   = mem_we & addr_sel;
    assign zero      = (alu_q == '0);
    assign carry     = carry_q;
    assign ovf       = ovf_q;
    assign store_err = store_err_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed instruction sequences checked by an
// arithmetic reference model every cycle, plus literal expectations at key points.
module tb_cpu_datapath;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic        alu_op = 1'b0, immediate = 1'b0;
    logic [15:0] imm_in = '0;
    logic        exec_strobe = 1'b0, reg_we = 1'b0, addr_sel = 1'b0, mem_we = 1'b0;
    logic [15:0] pc_in = 16'h0040;
    logic [15:0] mem_rdata = '0;
    logic [15:0] mem_addr, mem_wdata, alu_q;
    logic        mem_wen, zero, carry, ovf, store_err;

    int n_tests = 0;
    int n_fail  = 0;

    cpu_datapath dut (
        .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rd(rd), .alu_op(alu_op),
        .immediate(immediate), .imm_in(imm_in), .exec_strobe(exec_strobe), .reg_we(reg_we),
        .addr_sel(addr_sel), .mem_we(mem_we), .pc_in(pc_in), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .alu_q(alu_q),
        .zero(zero), .carry(carry), .ovf(ovf), .store_err(store_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic over the architectural state.
    logic [15:0] m_rf [4];
    logic [15:0] m_alu, m_b, m_mdr;
    logic [1:0]  m_dst;
    logic        m_mem, m_c, m_v, m_err;

    function automatic logic [17:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                            input logic sub);
        int ua, ub, sa, sb, r, sr;
        logic c, v;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            r  = ua - ub;
            c  = (ua >= ub);
            sr = sa - sb;
        end else begin
            r  = ua + ub;
            c  = (r > 65535);
            sr = sa + sb;
        end
        v = (sr > 32767) || (sr < -32768);
        return {v, c, r[15:0]};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) m_rf[i] <= '0;
            m_alu <= '0; m_b <= '0; m_mdr <= '0; m_dst <= '0;
            m_mem <= 1'b0; m_c <= 1'b0; m_v <= 1'b0; m_err <= 1'b0;
        end else begin
            if (exec_strobe) begin
                logic [17:0] res;
                res = alu_ref(m_rf[rs1], immediate ? imm_in : m_rf[rs2], alu_op);
                m_alu <= res[15:0];
                m_c   <= res[16];
                m_v   <= res[17];
                m_b   <= m_rf[rs2];
                m_dst <= immediate ? rs2 : rd;
                m_mem <= immediate;
            end
            if (reg_we) m_rf[m_dst] <= m_mem ? m_mdr : m_alu;
            if (addr_sel && !mem_we) m_mdr <= mem_rdata;
            if (mem_we && !addr_sel) m_err <= 1'b1;
        end
    end

    always @(negedge clk) begin
        check("cyc mem_addr", mem_addr, addr_sel ? m_alu : pc_in);
        check("cyc mem_wdata", mem_wdata, m_b);
        check("cyc mem_wen", mem_wen, mem_we && addr_sel);
        check("cyc alu_q", alu_q, m_alu);
        check("cyc zero", zero, m_alu == 16'h0);
        check("cyc carry", carry, m_c);
        check("cyc ovf", ovf, m_v);
        check("cyc store_err", store_err, m_err);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        exec_strobe = 1'b0; reg_we = 1'b0; addr_sel = 1'b0; mem_we = 1'b0;
        immediate = 1'b0; alu_op = 1'b0;
    endtask

    task automatic exec(input logic imm, input logic op, input logic [1:0] a,
                        input logic [1:0] b, input logic [1:0] d, input logic [15:0] k);
        exec_strobe = 1'b1; immediate = imm; alu_op = op;
        rs1 = a; rs2 = b; rd = d; imm_in = k;
    endtask

    // Reads a register through the ALU (R + 0) and the store-data path.
    task automatic read_reg(input logic [1:0] r, input logic [15:0] exp, input string name);
        idle();
        exec(1'b1, 1'b0, r, r, 2'd0, 16'h0000);
        tick();
        idle();
        check({name, " alu"}, alu_q, exp);
        check({name, " wdata"}, mem_wdata, exp);
    endtask

    task automatic load_reg(input logic [1:0] r, input logic [15:0] val);
        idle();
        exec(1'b1, 1'b0, 2'd0, r, 2'd0, 16'h0020);
        tick();
        idle();
        addr_sel = 1'b1; mem_rdata = val;
        tick();
        idle();
        reg_we = 1'b1;
        tick();
        idle();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #3;
        check("reset store_err", store_err, 0);
        check("reset alu_q", alu_q, 0);
        #4;
        reset = 1'b0;
        tick();
    endtask

    initial begin
        #1 reset = 1'b1;
        #2;
        check("rst mem_addr", mem_addr, 16'h0040);
        check("rst mem_wen", mem_wen, 0);
        check("rst alu_q", alu_q, 0);
        check("rst zero", zero, 1);
        #10 reset = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) read_reg(2'(i), 16'h0000, "rst reg");

        // LOAD R1 <- mem[R0 + 5]
        pc_in = 16'h0041;
        exec(1'b1, 1'b0, 2'd0, 2'd1, 2'd0, 16'h0005);
        tick();
        idle();
        check("load alu_q", alu_q, 16'h0005);
        addr_sel = 1'b1; mem_rdata = 16'h1234;
        #2 check("load mem_addr", mem_addr, 16'h0005);
        tick();
        idle();
        reg_we = 1'b1;
        tick();
        idle();
        read_reg(2'd1, 16'h1234, "load R1");

        // ADD R3 = R1 + R2 with signed overflow, then SUB R0 = R2 - R2
        load_reg(2'd1, 16'h7FFF);
        load_reg(2'd2, 16'h0001);
        exec(1'b0, 1'b0, 2'd1, 2'd2, 2'd3, 16'h0000);
        tick();
        idle();
        check("add alu_q", alu_q, 16'h8000);
        check("add ovf", ovf, 1);
        check("add carry", carry, 0);
        reg_we = 1'b1;
        tick();
        idle();
        read_reg(2'd3, 16'h8000, "add R3");
        exec(1'b0, 1'b1, 2'd2, 2'd2, 2'd0, 16'h0000);
        tick();
        idle();
        check("sub zero", zero, 1);
        check("sub carry", carry, 1);
        check("sub ovf", ovf, 0);
        reg_we = 1'b1;
        tick();
        idle();
        read_reg(2'd0, 16'h0000, "sub R0");

        // STORE R2 -> mem[R1 - 1]
        load_reg(2'd2, 16'hBEEF);
        load_reg(2'd1, 16'h0010);
        exec(1'b1, 1'b0, 2'd1, 2'd2, 2'd0, 16'hFFFF);
        tick();
        idle();
        addr_sel = 1'b1; mem_we = 1'b1; mem_rdata = 16'hDEAD;
        #2;
        check("store mem_addr", mem_addr, 16'h000F);
        check("store mem_wdata", mem_wdata, 16'hBEEF);
        check("store mem_wen", mem_wen, 1);
        tick();
        idle();
        tick();
        read_reg(2'd0, 16'h0000, "store R0");
        read_reg(2'd1, 16'h0010, "store R1");
        read_reg(2'd2, 16'hBEEF, "store R2");
        read_reg(2'd3, 16'h8000, "store R3");

        // Store request with PC addressing is suppressed and flagged
        pc_in = 16'h0050;
        mem_we = 1'b1;
        #2 check("misuse mem_wen", mem_wen, 0);
        tick();
        idle();
        check("misuse store_err", store_err, 1);
        repeat (3) tick();
        check("misuse sticky", store_err, 1);

        // Reset in the middle of a LOAD drops the pending write-back
        exec(1'b1, 1'b0, 2'd0, 2'd2, 2'd0, 16'h0030);
        tick();
        idle();
        addr_sel = 1'b1; mem_rdata = 16'h5555;
        tick();
        idle();
        pulse_reset();
        read_reg(2'd2, 16'h0000, "midrst R2");

        // Same-edge write-back of R1 and execute reading old R1
        load_reg(2'd1, 16'h0002);
        exec(1'b1, 1'b0, 2'd0, 2'd1, 2'd0, 16'h0030);
        tick();
        idle();
        addr_sel = 1'b1; mem_rdata = 16'h0009;
        tick();
        idle();
        reg_we = 1'b1;
        exec(1'b1, 1'b0, 2'd1, 2'd3, 2'd0, 16'h0001);
        tick();
        idle();
        check("simul alu_q", alu_q, 16'h0003);
        read_reg(2'd1, 16'h0009, "simul R1");
        read_reg(2'd3, 16'h0000, "simul R3");

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
